fifo_uart_tx: RTL

Serial transmit stage that drains the 32-entry byte `fifo` and emits each byte as an 8N1 UART frame on `tx`. It sits directly downstream of the FIFO. It watches `empty`, pulses `read` for one cycle, and captures the registered FIFO `dataout` one cycle later. It then serialises the byte, LSB first, at a baud rate set by a clock-divider parameter.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_tick.sv | 31 +++
 rtl/fifo_uart_tx.sv | 86 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and framing constants
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } uart_state_t;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period divider producing a one-cycle tick
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] count;

    assign tick = (count == LAST);

    // Count 0..CLKS_PER_BIT-1 and wrap; clear restarts the bit period from zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains the byte FIFO and emits 8N1 frames on tx
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       empty,
    input  logic [7:0] fifo_data,
    output logic       read,
    output logic       tx,
    output logic       busy
);

    uart_state_t          state, state_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [2:0]           bit_idx, bit_idx_next;
    logic                 tx_next;
    logic                 tick;
    logic                 clear;

    // Every state change starts a fresh bit period
    assign clear = (state_next != state);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock(clock),
        .reset(reset),
        .clear(clear),
        .tick (tick)
    );

    // Strobes decode from the state register only, so they are clean through reset
    assign read = (state == REQ);
    assign busy = (state != IDLE);

    // State, shift register, bit index and the registered line output
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= 8'h00;
            bit_idx   <= 3'd0;
            tx        <= 1'b1;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_idx   <= bit_idx_next;
            tx        <= tx_next;
        end
    end

    // Next-state sequencing; tx is computed from the next state so it flips on the entering edge
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx;
        case (state)
            IDLE:  if (!empty) state_next = REQ;
            REQ:   state_next = LOAD;
            LOAD: begin
                // FIFO dataout is valid only in this cycle; it clears on the same edge
                shift_next = fifo_data;
                state_next = START;
            end
            START: if (tick) state_next = DATA;
            DATA: begin
                if (tick) begin
                    shift_next   = shift_reg >> 1;
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'(DATA_BITS - 1)) state_next = STOP;
                end
            end
            STOP:  if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule
